// File: rtl/mix_gain_sequencer.sv
// Gain-and-mix sequencer: latches NCH sample/gain pairs, streams them through a
// shared N-cycle multiplier, sums the Q0.N-scaled products and saturates to N bits.
module mix_gain_sequencer #(
  parameter int N   = 16,
  parameter int NCH = 4
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             start,
  input  logic [NCH*N-1:0] sample_bus,
  input  logic [NCH*N-1:0] gain_bus,
  output logic [N-1:0]     mix,
  output logic             done,
  output logic             clip,
  output logic             busy,
  output logic             mult_en,
  output logic [N-1:0]     mult_in1,
  output logic [N-1:0]     mult_in2,
  input  logic [2*N-1:0]   mult_result,
  input  logic             mult_sync
);

  localparam int AW = N + $clog2(NCH);
  localparam int CW = $clog2(NCH) + 1;
  localparam int IW = $clog2(NCH);
  localparam logic [AW-1:0] MAX_MIX = {{(AW-N){1'b0}}, {N{1'b1}}};

  // Handshake: start is a one-cycle request taken only in IDLE; done is a
  // one-cycle pulse with mix/clip valid from that cycle; mult_sync is honoured
  // only in RUN, where it marks mult_result as the finished product.

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t         state, state_d;
  logic [N-1:0]   samp_q [NCH];
  logic [N-1:0]   gain_q [NCH];
  logic [AW-1:0]  acc, acc_d;
  logic [CW-1:0]  rcv_cnt, rcv_cnt_d;
  logic [CW-1:0]  sel;
  logic [IW-1:0]  sel_i;
  logic [N-1:0]   term;
  logic [AW-1:0]  total;
  logic           latch, finish;
  logic           unused_lo;

  assign term      = mult_result[2*N-1:N];
  assign total     = acc + {{(AW-N){1'b0}}, term};
  assign unused_lo = ^mult_result[N-1:0];

  // Operand mux: channel 0 in LOAD, the next channel in RUN, zero past the end.
  always_comb begin
    sel      = '0;
    mult_in1 = '0;
    mult_in2 = '0;
    if (state == RUN) sel = rcv_cnt + CW'(1);
    sel_i = sel[IW-1:0];
    if (state != IDLE && sel < CW'(NCH)) begin
      mult_in1 = samp_q[sel_i];
      mult_in2 = gain_q[sel_i];
    end
  end

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    rcv_cnt_d = rcv_cnt;
    latch     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch     = 1'b1;
          acc_d     = '0;
          rcv_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (mult_sync) begin
          acc_d     = total;
          rcv_cnt_d = rcv_cnt + CW'(1);
          if (rcv_cnt == CW'(NCH-1)) begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      rcv_cnt <= '0;
      mix     <= '0;
      clip    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      mult_en <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        samp_q[i] <= '0;
        gain_q[i] <= '0;
      end
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      rcv_cnt <= rcv_cnt_d;
      done    <= finish;
      busy    <= (state_d != IDLE);
      mult_en <= (state_d == RUN);
      if (latch) begin
        for (int i = 0; i < NCH; i++) begin
          samp_q[i] <= sample_bus[i*N +: N];
          gain_q[i] <= gain_bus[i*N +: N];
        end
      end
      if (finish) begin
        mix  <= (total > MAX_MIX) ? {N{1'b1}} : total[N-1:0];
        clip <= (total > MAX_MIX);
      end
    end
  end

endmodule

// File: tb/tb_mix_gain_sequencer.sv
// Directed bench for mix_gain_sequencer with a behavioural model of the
// N-cycle shared multiplier (captures operands while en is low or on sync).
module tb_mix_gain_sequencer;

  localparam int N   = 16;
  localparam int NCH = 4;
  localparam int LAT = N*NCH + 1;  // done seen after edge S+65, sampled at S+66

  logic             mclk = 1'b0;
  logic             rst;
  logic             start;
  logic [NCH*N-1:0] sample_bus, gain_bus;
  logic [N-1:0]     mix;
  logic             done, clip, busy, mult_en, mult_sync;
  logic [N-1:0]     mult_in1, mult_in2;
  logic [2*N-1:0]   mult_result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 mclk = ~mclk;

  mix_gain_sequencer #(.N(N), .NCH(NCH)) dut (
    .mclk(mclk), .rst(rst), .start(start),
    .sample_bus(sample_bus), .gain_bus(gain_bus),
    .mix(mix), .done(done), .clip(clip), .busy(busy),
    .mult_en(mult_en), .mult_in1(mult_in1), .mult_in2(mult_in2),
    .mult_result(mult_result), .mult_sync(mult_sync)
  );

  // Multiplier model: sync is raised in the N-th enabled cycle, result is the
  // product of the operands captured when the run began.
  int             m_cnt = 0;
  logic [2*N-1:0] m_prod = '0;
  assign mult_sync   = mult_en && (m_cnt == N-1);
  assign mult_result = m_prod;
  always @(posedge mclk) begin
    if (!mult_en || mult_sync) begin
      m_prod <= {{N{1'b0}}, mult_in1} * {{N{1'b0}}, mult_in2};
      m_cnt  <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  typedef struct {
    logic [NCH*N-1:0] samp;
    logic [NCH*N-1:0] gain;
    logic [N-1:0]     mix;
    logic             clip;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [NCH*N-1:0] pack(input logic [N-1:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Caller is at a negedge; returns at the negedge after start edge S.
  task automatic start_run(input logic [NCH*N-1:0] s, input logic [NCH*N-1:0] g);
    sample_bus = s;
    gain_bus   = g;
    start      = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("load_in1", {16'b0, mult_in1}, {16'b0, s[N-1:0]});
    check("load_in2", {16'b0, mult_in2}, {16'b0, g[N-1:0]});
  endtask

  // Iteration n sits at the negedge after edge S+n.
  task automatic wait_done(input int chg_at, input int restart_at, input int rst_at, input int budget,
                           output bit got, output int lat, output int en_cyc, output int busy_cyc);
    got = 0; lat = 0; en_cyc = 0; busy_cyc = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge mclk);
      @(negedge mclk);
      if (n == chg_at) begin
        sample_bus = {NCH*N{1'b1}};
        gain_bus   = {NCH*N{1'b1}};
      end
      if (n == restart_at - 1) start = 1'b1;
      if (n == restart_at)     start = 1'b0;
      if (n == rst_at - 1)     rst   = 1'b1;
      if (n == rst_at) begin
        rst = 1'b0;
        break;
      end
      if (mult_en) en_cyc++;
      if (busy) busy_cyc++;
      if (done) begin
        got = 1;
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_run(input string name, input vec_t v, input bit got, input int lat,
                           input int en_cyc, input int busy_cyc);
    check({name, "_done_seen"}, {31'b0, got}, 32'd1);
    check({name, "_latency"}, lat, LAT);
    check({name, "_mix"}, {16'b0, mix}, {16'b0, v.mix});
    check({name, "_clip"}, {31'b0, clip}, {31'b0, v.clip});
    check({name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    check({name, "_en_cycles"}, en_cyc, N*NCH);
    check({name, "_busy_cycles"}, busy_cyc, N*NCH);
  endtask

  initial begin
    bit   got;
    int   lat, en_cyc, busy_cyc, bad;
    vec_t v;

    vecs[0] = '{pack(16'h8000, 0, 0, 0), pack(16'h8000, 0, 0, 0), 16'h4000, 1'b0};
    vecs[1] = '{pack(16'h1000, 16'h2000, 16'h3000, 16'h4000), {NCH{16'hFFFF}}, 16'h9FFC, 1'b0};
    vecs[2] = '{{NCH{16'hFFFF}}, {NCH{16'hFFFF}}, 16'hFFFF, 1'b1};
    vecs[3] = '{{NCH{16'h4000}}, {NCH{16'h8000}}, 16'h8000, 1'b0};
    // Exactly full scale (0x7FFF+0x7FFF+1) does not clip; one more LSB does.
    vecs[4] = '{pack(16'h8000, 16'h8000, 16'h0100, 0), pack(16'hFFFF, 16'hFFFF, 16'h0100, 0), 16'hFFFF, 1'b0};
    vecs[5] = '{pack(16'h8000, 16'h8000, 16'h0100, 16'h0100), pack(16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100), 16'hFFFF, 1'b1};

    rst = 1'b1; start = 1'b0; sample_bus = '0; gain_bus = '0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    rst = 1'b0;
    check("rst_mix", {16'b0, mix}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_clip", {31'b0, clip}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mult_en", {31'b0, mult_en}, 32'd0);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (mix != 0 || clip || done || busy || mult_en) bad++;
    end
    check("idle_100_quiet", bad, 0);

    for (int i = 0; i < 6; i++) begin
      start_run(vecs[i].samp, vecs[i].gain);
      wait_done(-1, -1, -1, 150, got, lat, en_cyc, busy_cyc);
      check_run($sformatf("vec%0d", i), vecs[i], got, lat, en_cyc, busy_cyc);
      @(negedge mclk);
      check($sformatf("vec%0d_done_width", i), {31'b0, done}, 32'd0);
      repeat ($urandom_range(3, 0)) @(negedge mclk);
    end

    // Restart attempt at S+10 and bus change from S+5 must not disturb the run.
    start_run(vecs[1].samp, vecs[1].gain);
    wait_done(4, 10, -1, 150, got, lat, en_cyc, busy_cyc);
    check_run("ignore", vecs[1], got, lat, en_cyc, busy_cyc);
    @(negedge mclk);
    @(negedge mclk);
    check("ignore_no_queue_busy", {31'b0, busy}, 32'd0);
    check("ignore_no_queue_en", {31'b0, mult_en}, 32'd0);

    // Leave clip=1 and a nonzero mix, then reset at S+30.
    start_run(vecs[2].samp, vecs[2].gain);
    wait_done(-1, -1, -1, 150, got, lat, en_cyc, busy_cyc);
    check_run("pre_rst", vecs[2], got, lat, en_cyc, busy_cyc);
    @(negedge mclk);
    start_run(vecs[1].samp, vecs[1].gain);
    wait_done(-1, -1, 30, 150, got, lat, en_cyc, busy_cyc);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_en", {31'b0, mult_en}, 32'd0);
    check("rst_mid_mix", {16'b0, mix}, 32'd0);
    check("rst_mid_clip", {31'b0, clip}, 32'd0);
    wait_done(-1, -1, -1, 100, got, lat, en_cyc, busy_cyc);
    check("rst_mid_no_done", {31'b0, got}, 32'd0);
    start_run(vecs[3].samp, vecs[3].gain);
    wait_done(-1, -1, -1, 150, got, lat, en_cyc, busy_cyc);
    check_run("after_rst", vecs[3], got, lat, en_cyc, busy_cyc);

    // Back-to-back: start issued in the done cycle is accepted.
    @(negedge mclk);
    start_run(vecs[0].samp, vecs[0].gain);
    wait_done(-1, -1, -1, 150, got, lat, en_cyc, busy_cyc);
    check_run("b2b_first", vecs[0], got, lat, en_cyc, busy_cyc);
    v = vecs[1];
    start_run(v.samp, v.gain);
    wait_done(-1, -1, -1, 150, got, lat, en_cyc, busy_cyc);
    check_run("b2b_second", v, got, lat, en_cyc, busy_cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
